// File: rtl/inst_loader.sv
// Boot-time program loader: frames a UART byte stream into big-endian words for the fetcher
// and holds the core in reset until a checksum-verified frame completes. Option: INST_LOADER_TIMEOUT_EN.
module inst_loader #(
    parameter int          MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        load_valid,
    output logic [31:0] load_addr,
    output logic [31:0] load_inst,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAXW = 17'(MAX_WORDS);

    state_t      r_state;
    logic        r_inReady;
    logic        r_loadValid;
    logic [31:0] r_loadAddr;
    logic [31:0] r_loadInst;
    logic        r_cpuHold;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_wordCount;
    logic [7:0]  r_checksum;
    logic [7:0]  r_lenHi;
    logic [15:0] r_len;
    logic [23:0] r_asm;
    logic [1:0]  r_byteIdx;

    logic        w_xfer;
    logic [15:0] w_len;

    assign w_xfer = in_valid && r_inReady;
    assign w_len  = {r_lenHi, in_data};

`ifdef INST_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idleCnt;
    logic          w_counting;
    assign w_counting = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                        (r_state == S_DATA)   || (r_state == S_CHECK);
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_inReady   <= 1'b1;
            r_loadValid <= 1'b0;
            r_loadAddr  <= '0;
            r_loadInst  <= '0;
            r_cpuHold   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wordCount <= '0;
            r_checksum  <= '0;
            r_lenHi     <= '0;
            r_len       <= '0;
            r_asm       <= '0;
            r_byteIdx   <= '0;
`ifdef INST_LOADER_TIMEOUT_EN
            r_idleCnt   <= '0;
`endif
        end else begin
            r_loadValid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_xfer && in_data == SYNC_BYTE) begin
                        r_state     <= S_LEN_HI;
                        r_cpuHold   <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_wordCount <= '0;
                        r_checksum  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_lenHi <= in_data;
                        r_state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == 16'd0 || {1'b0, w_len} > MAXW) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state   <= S_DATA;
                            r_byteIdx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm      <= {r_asm[15:0], in_data};
                        r_checksum <= r_checksum ^ in_data;
                        r_byteIdx  <= r_byteIdx + 2'd1;
                        // Write strobe lands in the cycle right after the 4th byte handshake.
                        if (r_byteIdx == 2'd3) begin
                            r_loadInst  <= {r_asm, in_data};
                            r_loadAddr  <= {14'd0, r_wordCount, 2'b00};
                            r_loadValid <= 1'b1;
                            r_inReady   <= 1'b0;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_inReady   <= 1'b1;
                    r_wordCount <= r_wordCount + 16'd1;
                    if (r_wordCount + 16'd1 == r_len) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        if (in_data == r_checksum) begin
                            r_state   <= S_DONE;
                            r_cpuHold <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef INST_LOADER_TIMEOUT_EN
            // A stalled sender inside a frame aborts it; overrides the case above.
            if (w_counting) begin
                if (w_xfer) begin
                    r_idleCnt <= '0;
                end else if (r_idleCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_idleCnt <= '0;
                    r_state   <= S_ERROR;
                    r_error   <= 1'b1;
                end else begin
                    r_idleCnt <= r_idleCnt + 1'b1;
                end
            end else begin
                r_idleCnt <= '0;
            end
`endif
        end
    end

    assign in_ready   = r_inReady;
    assign load_valid = r_loadValid;
    assign load_addr  = r_loadAddr;
    assign load_inst  = r_loadInst;
    assign cpu_hold   = r_cpuHold;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_wordCount;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader: frames are built from a word-level model,
// expected writes are queued and a negedge monitor pops them as load_valid strobes appear.
module tb_inst_loader;

    localparam int MAX_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_inst;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    wr_t         expQ[$];
    logic [31:0] stimWords[$];
    logic        prevLv = 1'b0;
    wr_t         monEntry;

    inst_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .load_valid(load_valid), .load_addr(load_addr), .load_inst(load_inst),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst) begin
            if (load_valid) begin
                checkOutput("no_back_to_back_write", {31'd0, prevLv}, 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write actual addr=0x%0h inst=0x%0h expected none", load_addr, load_inst);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("load_addr", load_addr, monEntry.addr);
                    checkOutput("load_inst", load_inst, monEntry.inst);
                end
            end
            checkOutput("in_ready_low_only_in_write", {31'd0, in_ready}, {31'd0, !load_valid});
            prevLv = load_valid;
        end else begin
            prevLv = 1'b0;
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte_accept_timeout actual in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
    endtask

    task automatic gap(input int gapMax);
        if (gapMax > 0) idleCycles($urandom_range(0, gapMax));
    endtask

    task automatic checkResetValues();
        checkOutput("reset_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_error", {31'd0, error}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_load_valid", {31'd0, load_valid}, 32'd0);
        checkOutput("reset_word_count", {16'd0, word_count}, 32'd0);
    endtask

    // Sends one frame built from stimWords; sumOverride < 0 sends the true checksum.
    task automatic applyStimulus(input logic [15:0] lenField, input int sumOverride,
                                 input int gapMax, input int garbage);
        logic [7:0]  sum;
        logic [7:0]  sent;
        logic [7:0]  b;
        logic [31:0] w;
        bit          lenOk;
        bit          expDone;
        int          n;
        for (int g = 0; g < garbage; g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            gap(gapMax);
            sendByte(b);
        end
        gap(gapMax);
        sendByte(8'hA5);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("sync_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("sync_done_clear", {31'd0, done}, 32'd0);
        checkOutput("sync_error_clear", {31'd0, error}, 32'd0);
        n     = int'(lenField);
        lenOk = (n != 0) && (n <= MAX_WORDS);
        gap(gapMax);
        sendByte(lenField[15:8]);
        gap(gapMax);
        sendByte(lenField[7:0]);
        sum = 8'h00;
        if (lenOk) begin
            for (int i = 0; i < n; i++) begin
                w = stimWords[i];
                expQ.push_back('{addr: 32'(i * 4), inst: w});
                for (int j = 0; j < 4; j++) begin
                    b   = w[31 - 8*j -: 8];
                    sum = sum ^ b;
                    gap(gapMax);
                    sendByte(b);
                end
            end
            sent = (sumOverride < 0) ? sum : sumOverride[7:0];
            gap(gapMax);
            sendByte(sent);
            expDone = (sent == sum);
        end else begin
            expDone = 1'b0;
        end
        idleCycles(3);
        checkOutput("frame_done", {31'd0, done}, {31'd0, expDone});
        checkOutput("frame_error", {31'd0, error}, {31'd0, !expDone});
        checkOutput("frame_cpu_hold", {31'd0, cpu_hold}, {31'd0, !expDone});
        checkOutput("frame_word_count", {16'd0, word_count}, lenOk ? 32'(n) : 32'd0);
        checkOutput("frame_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("frame_writes_drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic randomWords(input int n);
        stimWords.delete();
        for (int i = 0; i < n; i++) stimWords.push_back($urandom());
    endtask

    initial begin
        int          r;
        int          n;
        int          so;
        logic [15:0] len;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkResetValues();

        stimWords.delete();
        stimWords.push_back(32'h20080005);
        stimWords.push_back(32'h00000008);
        applyStimulus(16'd2, -1, 0, 0);
        applyStimulus(16'd2, 0, 0, 0);

        stimWords.delete();
        applyStimulus(16'd0, -1, 0, 1);
        applyStimulus(16'(MAX_WORDS + 1), -1, 0, 0);
        randomWords(1);
        applyStimulus(16'd1, -1, 2, 1);

        randomWords(1);
        applyStimulus(16'd1, -1, 0, 0);

        // Reset in the middle of a frame, two data bytes in.
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues();
        randomWords(1);
        applyStimulus(16'd1, -1, 1, 0);

        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 99);
            n = $urandom_range(1, 6);
            if (r < 5)       len = 16'd0;
            else if (r < 10) len = 16'($urandom_range(MAX_WORDS + 1, 65535));
            else             len = 16'(n);
            randomWords(n);
            so = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            applyStimulus(len, so, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        idleCycles(4);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
